// File: rtl/eer_rl_pkg.sv
// Shared types and constants for the EER-RL node datapath: packet layout,
// scheduler FSM encoding and a saturating counter helper.
package eer_rl_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int ADDR_WIDTH = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_ABORT
  } sched_state_e;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] src;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] qvalue;
    logic [WORD_WIDTH-1:0] cluster;
  } nbr_pkt_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Small synchronous FIFO for neighbour packets; registered occupancy count,
// combinational read of the head entry.
module pkt_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately left out of reset; only pointers and count
  // define validity, so clearing the array would cost flops for nothing.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/qtable_update_sched.sv
// Buffers neighbour advertisements and launches one QTableUpdate at a time,
// dropping self-originated packets and aborting updates that never finish.
module qtable_update_sched
  import eer_rl_pkg::*;
#(
  parameter int                    WORD_WIDTH = eer_rl_pkg::WORD_WIDTH,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    TIMEOUT    = 4096,
  parameter logic [WORD_WIDTH-1:0] MY_ID      = WORD_WIDTH'(1)
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  pkt_valid,
  input  logic [WORD_WIDTH-1:0] pkt_src,
  input  logic [WORD_WIDTH-1:0] pkt_energy,
  input  logic [WORD_WIDTH-1:0] pkt_qvalue,
  input  logic [WORD_WIDTH-1:0] pkt_cluster,
  output logic                  pkt_ready,
  output logic                  upd_en,
  output logic                  upd_start,
  output logic [WORD_WIDTH-1:0] upd_src,
  output logic [WORD_WIDTH-1:0] upd_energy,
  output logic [WORD_WIDTH-1:0] upd_qvalue,
  output logic [WORD_WIDTH-1:0] upd_cluster,
  input  logic                  upd_done,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [15:0]           upd_count,
  output logic [15:0]           skip_count,
  output logic [15:0]           timeout_count
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] src;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] qvalue;
    logic [WORD_WIDTH-1:0] cluster;
  } pkt_t;

  sched_state_e       state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  pkt_t               fields_q, fields_d;
  logic [15:0]        upd_count_q, upd_count_d;
  logic [15:0]        skip_count_q, skip_count_d;
  logic [15:0]        timeout_count_q, timeout_count_d;

  pkt_t               fifo_din;
  pkt_t               fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;

  assign fifo_din  = '{src: pkt_src, energy: pkt_energy, qvalue: pkt_qvalue, cluster: pkt_cluster};
  assign pkt_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_push = pkt_valid && !fifo_full;

  pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pkt_t))
  ) u_fifo (
    .clock (clock),
    .nrst  (nrst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    fields_d        = fields_q;
    upd_count_d     = upd_count_q;
    skip_count_d    = skip_count_q;
    timeout_count_d = timeout_count_q;
    fifo_pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && !fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        fields_d = fifo_head;
        if (fifo_head.src == MY_ID) begin
          skip_count_d = sat_inc16(skip_count_q);
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion takes priority over an expiry on the same cycle.
        if (upd_done) begin
          upd_count_d = sat_inc16(upd_count_q);
          state_d     = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_ABORT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_ABORT: begin
        timeout_count_d = sat_inc16(timeout_count_q);
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      fields_q        <= '0;
      upd_count_q     <= '0;
      skip_count_q    <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      fields_q        <= fields_d;
      upd_count_q     <= upd_count_d;
      skip_count_q    <= skip_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  // Engine controls decode straight from the registered state; ABORT holds
  // upd_en low for one cycle, which the engine treats as a reset.
  assign upd_start     = (state_q == ST_START);
  assign upd_en        = (state_q == ST_START) || (state_q == ST_WAIT);
  assign timeout_err   = (state_q == ST_ABORT);
  assign busy          = !fifo_empty || (state_q != ST_IDLE);
  assign upd_src       = fields_q.src;
  assign upd_energy    = fields_q.energy;
  assign upd_qvalue    = fields_q.qvalue;
  assign upd_cluster   = fields_q.cluster;
  assign upd_count     = upd_count_q;
  assign skip_count    = skip_count_q;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_qtable_update_sched.sv
// Directed bench for qtable_update_sched: launch latency, FIFO back-pressure,
// self-packet skipping, timeout abort, enable gating and mid-update reset.
module tb_qtable_update_sched;
  import eer_rl_pkg::*;

  logic        clock = 1'b0;
  logic        nrst, en, pkt_valid, upd_done;
  logic [15:0] pkt_src, pkt_energy, pkt_qvalue, pkt_cluster;
  logic        pkt_ready, upd_en, upd_start, busy, timeout_err;
  logic [15:0] upd_src, upd_energy, upd_qvalue, upd_cluster;
  logic [15:0] upd_count, skip_count, timeout_count;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_upd = 0;
  int last_edges = 0;

  qtable_update_sched #(
    .WORD_WIDTH (16),
    .FIFO_DEPTH (4),
    .TIMEOUT    (16),
    .MY_ID      (16'h0001)
  ) dut (
    .clock         (clock),
    .nrst          (nrst),
    .en            (en),
    .pkt_valid     (pkt_valid),
    .pkt_src       (pkt_src),
    .pkt_energy    (pkt_energy),
    .pkt_qvalue    (pkt_qvalue),
    .pkt_cluster   (pkt_cluster),
    .pkt_ready     (pkt_ready),
    .upd_en        (upd_en),
    .upd_start     (upd_start),
    .upd_src       (upd_src),
    .upd_energy    (upd_energy),
    .upd_qvalue    (upd_qvalue),
    .upd_cluster   (upd_cluster),
    .upd_done      (upd_done),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .upd_count     (upd_count),
    .skip_count    (skip_count),
    .timeout_count (timeout_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic nbr_pkt_t mk(input logic [15:0] s, e, q, c);
    return '{src: s, energy: e, qvalue: q, cluster: c};
  endfunction

  // Offers one packet until accepted; acc_cyc is the accepting edge or -1.
  task automatic push_pkt(input nbr_pkt_t p, input int budget, output int acc_cyc);
    logic r;
    acc_cyc     = -1;
    pkt_valid   = 1'b1;
    pkt_src     = p.src;
    pkt_energy  = p.energy;
    pkt_qvalue  = p.qvalue;
    pkt_cluster = p.cluster;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      r = pkt_ready;
      @(posedge clock);
      #1;
      if (r) begin
        acc_cyc = cyc;
        break;
      end
    end
    pkt_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int edges);
    edges = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #1;
      if (upd_start) begin
        edges = i + 1;
        break;
      end
    end
  endtask

  // Acts as the engine for one update: waits for start, checks the source,
  // answers with done after 'delay' WAIT cycles.
  task automatic serve(input logic [15:0] exp_src, input int delay);
    int e;
    wait_start(64, e);
    last_edges = e;
    n_checks++;
    if (e < 0) begin
      n_fail++;
      $display("FAIL serve_start src=%0d: no upd_start within 64 cycles", exp_src);
    end else begin
      n_checks++;
      if (upd_src !== exp_src) begin
        n_fail++;
        $display("FAIL serve_src: upd_src=%0d expected %0d", upd_src, exp_src);
      end
      @(posedge clock); #1;
      repeat (delay) begin @(posedge clock); #1; end
      upd_done = 1'b1;
      @(posedge clock); #1;
      upd_done = 1'b0;
      exp_upd++;
      n_checks++;
      if (upd_count !== 16'(exp_upd)) begin
        n_fail++;
        $display("FAIL serve_count src=%0d: upd_count=%0d expected %0d", exp_src, upd_count, exp_upd);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if ({pkt_ready, upd_en, upd_start, busy, timeout_err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL %s_ctrl: {ready,en,start,busy,terr}=%b expected 10000", tag,
               {pkt_ready, upd_en, upd_start, busy, timeout_err});
    end
    n_checks++;
    if ({upd_count, skip_count, timeout_count} !== 48'd0) begin
      n_fail++;
      $display("FAIL %s_counters: upd=%0d skip=%0d tmo=%0d expected 0", tag, upd_count, skip_count, timeout_count);
    end
    n_checks++;
    if ({upd_src, upd_energy, upd_qvalue, upd_cluster} !== 64'd0) begin
      n_fail++;
      $display("FAIL %s_fields: src=%0d energy=%0d q=%0d cl=%0d expected 0", tag,
               upd_src, upd_energy, upd_qvalue, upd_cluster);
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0; en = 1'b0; pkt_valid = 1'b0; upd_done = 1'b0;
    pkt_src = '0; pkt_energy = '0; pkt_qvalue = '0; pkt_cluster = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("reset");
    nrst = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single;
    int acc;
    en = 1'b1;
    push_pkt(mk(16'd5, 16'd100, 16'd20, 16'd2), 8, acc);
    n_checks++;
    if (acc < 0 || busy !== 1'b1 || upd_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: acc=%0d busy=%b start=%b expected busy=1 start=0", acc, busy, upd_start);
    end
    @(posedge clock); #1;
    n_checks++;
    if (upd_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_n1: upd_start=%b expected 0 at N+1", upd_start);
    end
    @(posedge clock); #1;
    n_checks++;
    if (upd_start !== 1'b1 || upd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL single_n2: start=%b en=%b expected 1 1 at N+2", upd_start, upd_en);
    end
    n_checks++;
    if ({upd_src, upd_energy, upd_qvalue, upd_cluster} !== {16'd5, 16'd100, 16'd20, 16'd2}) begin
      n_fail++;
      $display("FAIL single_fields: %0d/%0d/%0d/%0d expected 5/100/20/2", upd_src, upd_energy, upd_qvalue, upd_cluster);
    end
    @(posedge clock); #1;
    n_checks++;
    if (upd_start !== 1'b0 || upd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL single_wait: start=%b en=%b expected 0 1", upd_start, upd_en);
    end
    repeat (5) begin @(posedge clock); #1; end
    upd_done = 1'b1;
    @(posedge clock); #1;
    upd_done = 1'b0;
    exp_upd = 1;
    n_checks++;
    if (upd_count !== 16'd1 || upd_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: count=%0d en=%b busy=%b expected 1 0 0", upd_count, upd_en, busy);
    end
    @(posedge clock); #1;
    n_checks++;
    if (busy !== 1'b0 || upd_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b start=%b expected 0 0", busy, upd_start);
    end
  endtask

  task automatic test_back_to_back;
    int acc, acc5, e_cyc;
    logic quiet;
    en = 1'b0;
    for (int i = 0; i < 4; i++) push_pkt(mk(16'(10 + i), 16'(200 + i), 16'd7, 16'd3), 4, acc);
    n_checks++;
    if (pkt_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_full: ready=%b busy=%b expected 0 1", pkt_ready, busy);
    end
    quiet = 1'b1;
    repeat (3) begin @(posedge clock); #1; if (upd_start !== 1'b0 || pkt_ready !== 1'b0) quiet = 1'b0; end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL b2b_hold: start/ready changed while en low, expected start=0 ready=0");
    end
    e_cyc = cyc;
    fork
      push_pkt(mk(16'd14, 16'd204, 16'd7, 16'd3), 30, acc5);
      begin
        en = 1'b1;
        serve(16'd10, 1);
        for (int i = 1; i < 5; i++) begin
          serve(16'(10 + i), 1);
          n_checks++;
          if (last_edges !== 2) begin
            n_fail++;
            $display("FAIL b2b_latency src=%0d: start %0d edges after done, expected 2", 10 + i, last_edges);
          end
        end
      end
    join
    n_checks++;
    if (acc5 !== e_cyc + 3) begin
      n_fail++;
      $display("FAIL b2b_fifth: accepted at edge %0d expected %0d", acc5, e_cyc + 3);
    end
    n_checks++;
    if (busy !== 1'b0 || pkt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drain: busy=%b ready=%b expected 0 1", busy, pkt_ready);
    end
  endtask

  task automatic test_skip;
    int acc;
    en = 1'b1;
    push_pkt(mk(16'h0001, 16'd50, 16'd5, 16'd1), 4, acc);
    push_pkt(mk(16'd9, 16'd60, 16'd6, 16'd1), 4, acc);
    serve(16'd9, 1);
    n_checks++;
    if (last_edges !== 3) begin
      n_fail++;
      $display("FAIL skip_latency: start %0d edges after 2nd push, expected 3", last_edges);
    end
    n_checks++;
    if (skip_count !== 16'd1) begin
      n_fail++;
      $display("FAIL skip_count: skip_count=%0d expected 1", skip_count);
    end
  endtask

  task automatic test_timeout;
    int acc, e;
    logic hold_ok;
    push_pkt(mk(16'd20, 16'd1, 16'd2, 16'd3), 4, acc);
    push_pkt(mk(16'd21, 16'd4, 16'd5, 16'd6), 4, acc);
    wait_start(16, e);
    n_checks++;
    if (e < 0) begin
      n_fail++;
      $display("FAIL tmo_start: no upd_start for src 20");
    end
    hold_ok = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock); #1;
      if (upd_en !== 1'b1 || timeout_err !== 1'b0) hold_ok = 1'b0;
    end
    n_checks++;
    if (!hold_ok) begin
      n_fail++;
      $display("FAIL tmo_hold: upd_en dropped or timeout_err before S+16");
    end
    @(posedge clock); #1;
    n_checks++;
    if (timeout_err !== 1'b1 || upd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_abort: terr=%b en=%b expected 1 0 at S+16", timeout_err, upd_en);
    end
    @(posedge clock); #1;
    n_checks++;
    if (timeout_err !== 1'b0 || timeout_count !== 16'd1) begin
      n_fail++;
      $display("FAIL tmo_after: terr=%b tmo_count=%0d expected 0 1", timeout_err, timeout_count);
    end
    // Done arrives on the very cycle the timer expires.
    serve(16'd21, 15);
    n_checks++;
    if (timeout_err !== 1'b0 || timeout_count !== 16'd1) begin
      n_fail++;
      $display("FAIL tmo_done_wins: terr=%b tmo_count=%0d expected 0 1", timeout_err, timeout_count);
    end
  endtask

  task automatic test_enable;
    int acc, e;
    logic quiet;
    en = 1'b0;
    push_pkt(mk(16'd30, 16'd0, 16'd0, 16'd0), 4, acc);
    push_pkt(mk(16'd31, 16'd0, 16'd0, 16'd0), 4, acc);
    quiet = 1'b1;
    repeat (5) begin @(posedge clock); #1; if (upd_start !== 1'b0 || upd_en !== 1'b0) quiet = 1'b0; end
    n_checks++;
    if (!quiet || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL en_gate: quiet=%b busy=%b expected 1 1", quiet, busy);
    end
    en = 1'b1;
    wait_start(8, e);
    n_checks++;
    if (e < 0 || upd_src !== 16'd30) begin
      n_fail++;
      $display("FAIL en_first: edges=%0d src=%0d expected start with src 30", e, upd_src);
    end
    @(posedge clock); #1;
    en = 1'b0;
    @(posedge clock); #1;
    upd_done = 1'b1;
    @(posedge clock); #1;
    upd_done = 1'b0;
    exp_upd++;
    n_checks++;
    if (upd_count !== 16'(exp_upd)) begin
      n_fail++;
      $display("FAIL en_complete: upd_count=%0d expected %0d", upd_count, exp_upd);
    end
    quiet = 1'b1;
    repeat (6) begin @(posedge clock); #1; if (upd_start !== 1'b0) quiet = 1'b0; end
    n_checks++;
    if (!quiet || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL en_second_blocked: quiet=%b busy=%b expected 1 1", quiet, busy);
    end
    en = 1'b1;
    serve(16'd31, 2);
  endtask

  task automatic test_reset_mid;
    int acc, e;
    logic quiet;
    en = 1'b1;
    push_pkt(mk(16'd40, 16'd1, 16'd1, 16'd1), 4, acc);
    push_pkt(mk(16'd41, 16'd1, 16'd1, 16'd1), 4, acc);
    wait_start(8, e);
    @(posedge clock); #1;
    n_checks++;
    if (e < 0 || upd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: edges=%0d upd_en=%b expected in WAIT", e, upd_en);
    end
    nrst = 1'b0;
    @(posedge clock); #1;
    check_reset_values("rst_mid");
    nrst = 1'b1;
    quiet = 1'b1;
    repeat (5) begin @(posedge clock); #1; if (upd_start !== 1'b0 || busy !== 1'b0) quiet = 1'b0; end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL rst_mid_empty: activity after reset, expected FIFO empty and idle");
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_skip;
    test_timeout;
    test_enable;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule
